// File: rtl/conv_pkg.sv
// Shared definitions for the line-window controller: read FSM states and
// small helpers that keep the buffer count and the window bit layout in one place.
package conv_pkg;

    // Read side FSM: wait for K full lines, then stream one window per column
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // One spare line buffer beyond the K being read lets writing continue
    // while a line group is streamed out
    function automatic int nbuf(input int k);
        return k + 1;
    endfunction

    // Flat element index of window element (r,c); r=0 is the oldest line
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage with a single write port and a K-wide
// read starting at rd_addr; columns past the right edge of the line read as zero.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int K      = 3,
    parameter int AW     = 12,
    parameter int IW     = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [K*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [IMG_W];
    logic [AW:0]       col;

    // Pixel storage; contents are never reset, stale data is overwritten before use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Gather K neighbouring columns, zero-filling beyond the last column
    always_comb begin
        rd_data = '0;
        col     = '0;
        for (int c = 0; c < K; c++) begin
            col = {1'b0, rd_addr} + (AW+1)'(c);
            if (col < (AW+1)'(IMG_W)) begin
                rd_data[c*DATA_W +: DATA_W] = mem[col[IW-1:0]];
            end
        end
    end

endmodule

// File: rtl/line_window_ctrl.sv
// Line-buffered KxK window generator: pixels arrive in raster order into a ring
// of K+1 line buffers; once K lines are resident, one window per column is issued
// to the downstream consumer and the oldest line is released at the end of the row.
module line_window_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int K      = 3
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic                  i_datavalid,
    input  logic [DATA_W-1:0]     idata,
    output logic                  s_axis_ready,
    input  logic                  m_axis_ready,
    output logic                  o_datavalid,
    output logic [K*K*DATA_W-1:0] o_window,
    output logic                  intr,
    output logic                  o_overflow
);

    localparam int NBUF = nbuf(K);
    localparam int CAP  = NBUF * IMG_W;
    localparam int CW   = $clog2(CAP + 1);
    localparam int BW   = $clog2(NBUF);
    localparam int IW   = $clog2(IMG_W);
    localparam int RW   = K * DATA_W;
    localparam int WW   = K * K * DATA_W;

    rd_state_e         state_q, state_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]     wr_buf_q, wr_buf_d;
    logic [BW-1:0]     rd_buf_q, rd_buf_d;
    logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
    logic              o_datavalid_q, o_datavalid_d;
    logic              intr_q, intr_d;
    logic              o_overflow_q, o_overflow_d;
    logic [WW-1:0]     o_window_q, o_window_d;

    logic              wr_en;
    logic              issue;
    logic              line_done;
    logic [RW-1:0]     buf_row [NBUF];
    logic [WW-1:0]     window_c;
    logic [BW:0]       row_sel;
    logic [RW-1:0]     row_data;

    // Space remains while fewer than NBUF full lines are held
    assign s_axis_ready = (fill_cnt_q < CW'(CAP));

    assign o_datavalid = o_datavalid_q;
    assign o_window    = o_window_q;
    assign intr        = intr_q;
    assign o_overflow  = o_overflow_q;

    for (genvar b = 0; b < NBUF; b++) begin : gen_buf
        line_buffer #(
            .DATA_W (DATA_W),
            .IMG_W  (IMG_W),
            .K      (K),
            .AW     (CW),
            .IW     (IW)
        ) u_line_buffer (
            .clk     (axis_clk),
            .wr_en   (wr_en && (wr_buf_q == BW'(b))),
            .wr_addr (wr_ptr_q[IW-1:0]),
            .wr_data (idata),
            .rd_addr (rd_ptr_q),
            .rd_data (buf_row[b])
        );
    end

    // Assemble the window: row r comes from buffer (rd_buf+r) mod NBUF
    always_comb begin
        window_c = '0;
        row_sel  = '0;
        row_data = '0;
        for (int r = 0; r < K; r++) begin
            row_sel = {1'b0, rd_buf_q} + (BW+1)'(r);
            if (row_sel >= (BW+1)'(NBUF)) begin
                row_sel = row_sel - (BW+1)'(NBUF);
            end
            row_data = '0;
            for (int b = 0; b < NBUF; b++) begin
                if (row_sel == (BW+1)'(b)) begin
                    row_data = buf_row[b];
                end
            end
            for (int c = 0; c < K; c++) begin
                window_c[win_idx(r, c, K)*DATA_W +: DATA_W] = row_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic for write pointers, read FSM, occupancy and outputs
    always_comb begin
        wr_en     = i_datavalid && s_axis_ready;
        issue     = (state_q == READ) && m_axis_ready;
        line_done = issue && (rd_ptr_q == CW'(IMG_W - 1));

        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_buf_d      = wr_buf_q;
        rd_buf_d      = rd_buf_q;
        fill_cnt_d    = fill_cnt_q;
        o_datavalid_d = issue;
        o_window_d    = o_window_q;
        intr_d        = line_done;
        o_overflow_d  = o_overflow_q | (i_datavalid & ~s_axis_ready);

        if (wr_en) begin
            if (wr_ptr_q == CW'(IMG_W - 1)) begin
                wr_ptr_d = '0;
                wr_buf_d = (wr_buf_q == BW'(NBUF - 1)) ? '0 : wr_buf_q + BW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
        end

        if (issue) begin
            o_window_d = window_c;
            if (line_done) begin
                rd_ptr_d = '0;
                rd_buf_d = (rd_buf_q == BW'(NBUF - 1)) ? '0 : rd_buf_q + BW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end

        fill_cnt_d = fill_cnt_q + CW'(wr_en) - (line_done ? CW'(IMG_W) : CW'(0));

        case (state_q)
            IDLE: begin
                if (fill_cnt_q >= CW'(K * IMG_W)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (line_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All controller state and registered outputs, cleared by the async reset
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_buf_q      <= '0;
            rd_buf_q      <= '0;
            fill_cnt_q    <= '0;
            o_datavalid_q <= 1'b0;
            intr_q        <= 1'b0;
            o_overflow_q  <= 1'b0;
            o_window_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_buf_q      <= wr_buf_d;
            rd_buf_q      <= rd_buf_d;
            fill_cnt_q    <= fill_cnt_d;
            o_datavalid_q <= o_datavalid_d;
            intr_q        <= intr_d;
            o_overflow_q  <= o_overflow_d;
            o_window_q    <= o_window_d;
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl with an 8-pixel line and 3x3 windows. Expected
// windows are built from the list of accepted pixels: line group g, column col.
module tb_line_window_ctrl;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int K      = 3;
    localparam int NBUF   = K + 1;
    localparam int CAP    = NBUF * IMG_W;
    localparam int WW     = K * K * DATA_W;

    logic              axis_clk = 1'b0;
    logic              axis_resetn = 1'b0;
    logic              i_datavalid = 1'b0;
    logic [DATA_W-1:0] idata = '0;
    logic              s_axis_ready;
    logic              m_axis_ready = 1'b0;
    logic              o_datavalid;
    logic [WW-1:0]     o_window;
    logic              intr;
    logic              o_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    int            acc[$];
    logic [WW-1:0] win_q[$];
    int            win_cyc[$];
    int            intr_cyc[$];
    int            ready_err;
    bit            model_ovf;
    bit            timeout;
    int            last_drive_cyc;
    int            cyc_g = 0;

    line_window_ctrl #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) dut (
        .axis_clk     (axis_clk),
        .axis_resetn  (axis_resetn),
        .i_datavalid  (i_datavalid),
        .idata        (idata),
        .s_axis_ready (s_axis_ready),
        .m_axis_ready (m_axis_ready),
        .o_datavalid  (o_datavalid),
        .o_window     (o_window),
        .intr         (intr),
        .o_overflow   (o_overflow)
    );

    // Free-running 100 MHz clock
    always #5 axis_clk = ~axis_clk;

    // Last-resort guard in case a wait is ever left unbounded
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Window for line group g (lines g..g+K-1) at column col, zero past the line end
    function automatic logic [WW-1:0] exp_window(input int g, input int col);
        logic [WW-1:0] w;
        int v;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (col + c < IMG_W) v = acc[(g + r) * IMG_W + col + c];
                else v = 0;
                w[(r * K + c) * DATA_W +: DATA_W] = DATA_W'(v);
            end
        end
        return w;
    endfunction

    task automatic clear_rec();
        acc.delete();
        win_q.delete();
        win_cyc.delete();
        intr_cyc.delete();
        ready_err = 0;
        model_ovf = 1'b0;
        timeout = 1'b0;
    endtask

    task automatic reset_dut();
        axis_resetn = 1'b0;
        i_datavalid = 1'b0;
        m_axis_ready = 1'b0;
        repeat (2) @(negedge axis_clk);
        axis_resetn = 1'b1;
        clear_rec();
    endtask

    // Drive pixels and read-enable at negedges, recording windows and intr pulses.
    // rmode: 0 never ready, 1 always ready, 2 toggling, 3 random.
    task automatic run_stream(input int npix, input int rmode, input bit respect,
                              input bit rnd_vals, input int gap_pct,
                              input int stop_wins, input int tail, input int budget);
        int sent;
        int cyc;
        int tail_left;
        int fill;
        bit exp_ready;
        bit done;
        sent = 0;
        cyc = 0;
        tail_left = tail;
        done = 1'b0;
        timeout = 1'b0;
        while (!done) begin
            @(negedge axis_clk);
            cyc++;
            cyc_g++;
            if (o_datavalid === 1'b1) begin
                win_q.push_back(o_window);
                win_cyc.push_back(cyc_g);
            end
            if (intr === 1'b1) intr_cyc.push_back(cyc_g);
            fill = acc.size() - IMG_W * (win_q.size() / IMG_W);
            exp_ready = (fill < CAP);
            if (s_axis_ready !== exp_ready) ready_err++;
            if (sent >= npix && win_q.size() >= stop_wins) begin
                if (tail_left == 0) done = 1'b1;
                else tail_left--;
            end
            if (!done && cyc > budget) begin
                timeout = 1'b1;
                done = 1'b1;
            end
            if (done) begin
                i_datavalid = 1'b0;
                m_axis_ready = 1'b0;
            end else begin
                case (rmode)
                    0: m_axis_ready = 1'b0;
                    1: m_axis_ready = 1'b1;
                    2: m_axis_ready = cyc_g[0];
                    default: m_axis_ready = 1'($urandom_range(0, 1));
                endcase
                if (sent < npix && (!respect || exp_ready) &&
                    ($urandom_range(0, 99) >= gap_pct)) begin
                    i_datavalid = 1'b1;
                    idata = rnd_vals ? DATA_W'($urandom) : DATA_W'(sent);
                    if (exp_ready) acc.push_back(int'(idata));
                    else model_ovf = 1'b1;
                    sent++;
                    last_drive_cyc = cyc_g;
                end else begin
                    i_datavalid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        axis_resetn = 1'b0;
        @(negedge axis_clk);
        for (int phase = 0; phase < 2; phase++) begin
            tests_run++;
            if (o_datavalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset o_datavalid: got %b expected 0", o_datavalid); end
            tests_run++;
            if (o_window !== '0) begin tests_failed++; $display("[TB] FAIL reset o_window: got %h expected 0", o_window); end
            tests_run++;
            if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset intr: got %b expected 0", intr); end
            tests_run++;
            if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset o_overflow: got %b expected 0", o_overflow); end
            tests_run++;
            if (s_axis_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset s_axis_ready: got %b expected 1", s_axis_ready); end
            axis_resetn = 1'b1;
            repeat (3) @(negedge axis_clk);
        end
    endtask

    task automatic test_single_group();
        int e_first[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        int e_last[9]  = '{7, 0, 0, 15, 0, 0, 23, 0, 0};
        logic [WW-1:0] w_first, w_last, exp;
        reset_dut();
        run_stream(24, 1, 1'b1, 1'b0, 0, 8, 4, 200);
        for (int i = 0; i < 9; i++) begin
            w_first[i*DATA_W +: DATA_W] = DATA_W'(e_first[i]);
            w_last[i*DATA_W +: DATA_W]  = DATA_W'(e_last[i]);
        end
        tests_run++;
        if (timeout || win_q.size() != 8) begin tests_failed++; $display("[TB] FAIL group window count: got %0d expected 8 (timeout=%0b)", win_q.size(), timeout); end
        for (int i = 0; i < win_q.size() && i < 8; i++) begin
            exp = exp_window(i / IMG_W, i % IMG_W);
            tests_run++;
            if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL group window %0d: got %h expected %h", i, win_q[i], exp); end
        end
        if (win_q.size() >= 8) begin
            tests_run++;
            if (win_q[0] !== w_first) begin tests_failed++; $display("[TB] FAIL group first window: got %h expected %h", win_q[0], w_first); end
            tests_run++;
            if (win_q[7] !== w_last) begin tests_failed++; $display("[TB] FAIL group eighth window: got %h expected %h", win_q[7], w_last); end
            tests_run++;
            if (win_cyc[0] != last_drive_cyc + 3) begin tests_failed++; $display("[TB] FAIL group first window cycle: got %0d expected %0d", win_cyc[0], last_drive_cyc + 3); end
            tests_run++;
            if (win_cyc[7] - win_cyc[0] != 7) begin tests_failed++; $display("[TB] FAIL group window span: got %0d expected 7", win_cyc[7] - win_cyc[0]); end
            tests_run++;
            if (intr_cyc.size() != 1 || intr_cyc[0] != win_cyc[7]) begin tests_failed++; $display("[TB] FAIL group intr: got %0d pulses expected 1 at cycle %0d", intr_cyc.size(), win_cyc[7]); end
        end
        tests_run++;
        if (ready_err != 0) begin tests_failed++; $display("[TB] FAIL group s_axis_ready: got %0d mismatching cycles expected 0", ready_err); end
    endtask

    task automatic test_overflow();
        logic [WW-1:0] exp;
        reset_dut();
        run_stream(33, 0, 1'b0, 1'b0, 0, 0, 3, 100);
        tests_run++;
        if (s_axis_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow s_axis_ready when full: got %b expected 0", s_axis_ready); end
        tests_run++;
        if (o_overflow !== model_ovf) begin tests_failed++; $display("[TB] FAIL overflow flag: got %b expected %b", o_overflow, model_ovf); end
        tests_run++;
        if (ready_err != 0) begin tests_failed++; $display("[TB] FAIL overflow ready tracking: got %0d mismatching cycles expected 0", ready_err); end
        tests_run++;
        if (win_q.size() != 0) begin tests_failed++; $display("[TB] FAIL overflow windows while stalled: got %0d expected 0", win_q.size()); end
        run_stream(0, 1, 1'b1, 1'b0, 0, 16, 6, 200);
        tests_run++;
        if (timeout || win_q.size() != 16) begin tests_failed++; $display("[TB] FAIL overflow drain count: got %0d expected 16", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 16; i++) begin
            exp = exp_window(i / IMG_W, i % IMG_W);
            tests_run++;
            if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL overflow drain window %0d: got %h expected %h", i, win_q[i], exp); end
        end
        tests_run++;
        if (intr_cyc.size() != 2) begin tests_failed++; $display("[TB] FAIL overflow drain intr: got %0d expected 2", intr_cyc.size()); end
        tests_run++;
        if (o_overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow sticky: got %b expected 1", o_overflow); end
    endtask

    task automatic test_toggle_ready();
        logic [WW-1:0] exp;
        reset_dut();
        run_stream(24, 2, 1'b1, 1'b0, 0, 8, 6, 300);
        tests_run++;
        if (timeout || win_q.size() != 8) begin tests_failed++; $display("[TB] FAIL toggle window count: got %0d expected 8", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 8; i++) begin
            exp = exp_window(i / IMG_W, i % IMG_W);
            tests_run++;
            if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL toggle window %0d: got %h expected %h", i, win_q[i], exp); end
        end
        if (win_q.size() >= 8) begin
            tests_run++;
            if (win_cyc[7] - win_cyc[0] != 14) begin tests_failed++; $display("[TB] FAIL toggle window span: got %0d expected 14", win_cyc[7] - win_cyc[0]); end
        end
        tests_run++;
        if (intr_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL toggle intr: got %0d expected 1", intr_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] exp;
        reset_dut();
        run_stream(6 * IMG_W, 1, 1'b1, 1'b0, 0, 32, 6, 400);
        tests_run++;
        if (timeout || win_q.size() != 32) begin tests_failed++; $display("[TB] FAIL b2b window count: got %0d expected 32", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 32; i++) begin
            exp = exp_window(i / IMG_W, i % IMG_W);
            tests_run++;
            if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL b2b window %0d: got %h expected %h", i, win_q[i], exp); end
        end
        tests_run++;
        if (intr_cyc.size() != 4) begin tests_failed++; $display("[TB] FAIL b2b intr: got %0d expected 4", intr_cyc.size()); end
        tests_run++;
        if (ready_err != 0) begin tests_failed++; $display("[TB] FAIL b2b s_axis_ready: got %0d mismatching cycles expected 0", ready_err); end
        tests_run++;
        if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b o_overflow: got %b expected 0", o_overflow); end
    endtask

    task automatic test_reset_mid_read();
        logic [WW-1:0] exp;
        reset_dut();
        run_stream(24, 1, 1'b1, 1'b0, 0, 4, 0, 200);
        tests_run++;
        if (timeout || o_datavalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset reach 4th window: got valid=%b expected 1", o_datavalid); end
        axis_resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (o_datavalid !== 1'b0 || o_window !== '0 || intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset outputs: got valid=%b intr=%b window=%h expected all 0", o_datavalid, intr, o_window); end
            tests_run++;
            if (s_axis_ready !== 1'b1 || o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset ready/overflow: got %b/%b expected 1/0", s_axis_ready, o_overflow); end
            @(negedge axis_clk);
        end
        axis_resetn = 1'b1;
        clear_rec();
        run_stream(24, 1, 1'b1, 1'b0, 0, 8, 4, 200);
        tests_run++;
        if (timeout || win_q.size() != 8) begin tests_failed++; $display("[TB] FAIL midreset resend count: got %0d expected 8", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 8; i++) begin
            exp = exp_window(i / IMG_W, i % IMG_W);
            tests_run++;
            if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL midreset resend window %0d: got %h expected %h", i, win_q[i], exp); end
        end
        tests_run++;
        if (intr_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL midreset resend intr: got %0d expected 1", intr_cyc.size()); end
    endtask

    task automatic test_random();
        logic [WW-1:0] exp;
        int lines, nexp;
        for (int it = 0; it < 3; it++) begin
            reset_dut();
            lines = $urandom_range(3, 6);
            nexp = (lines - K + 1) * IMG_W;
            run_stream(lines * IMG_W, 3, 1'b1, 1'b1, 30, nexp, 6, 3000);
            tests_run++;
            if (timeout || win_q.size() != nexp) begin tests_failed++; $display("[TB] FAIL random[%0d] window count: got %0d expected %0d", it, win_q.size(), nexp); end
            for (int i = 0; i < win_q.size() && i < nexp; i++) begin
                exp = exp_window(i / IMG_W, i % IMG_W);
                tests_run++;
                if (win_q[i] !== exp) begin tests_failed++; $display("[TB] FAIL random[%0d] window %0d: got %h expected %h", it, i, win_q[i], exp); end
            end
            tests_run++;
            if (intr_cyc.size() != lines - K + 1) begin tests_failed++; $display("[TB] FAIL random[%0d] intr: got %0d expected %0d", it, intr_cyc.size(), lines - K + 1); end
            tests_run++;
            if (ready_err != 0) begin tests_failed++; $display("[TB] FAIL random[%0d] s_axis_ready: got %0d mismatching cycles expected 0", it, ready_err); end
            tests_run++;
            if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL random[%0d] o_overflow: got %b expected 0", it, o_overflow); end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_group();
        test_overflow();
        test_toggle_ready();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
